tcdm_bank_resp_gen: RTL

Per-bank response generator for the low-latency TCDM interconnect. It tracks each request the bank grants through the fixed SRAM read latency and, when the data is due, raises exactly one `data_r_valid` bit towards the requesting master. Each master's combinational response fan-in tree consumes that bit. The generator never stalls: the response tree has no backpressure, and response order equals grant order.

---
 rtl/tcdm_bank_resp_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tcdm_bank_resp_gen.sv
// Per-bank TCDM response generator: follows each granted request through the SRAM
// latency and raises one one-hot response valid (plus gated read data) towards its master.
module tcdm_bank_resp_gen #(
    parameter int N_MASTER    = 16,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int OUT_REG     = 0,
    localparam int CNT_WIDTH  = $clog2(MEM_LATENCY + OUT_REG + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_gnt_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    input  logic                  req_wen_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [N_MASTER-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  drop_o,
    output logic [CNT_WIDTH-1:0]  inflight_o
);

    logic                stage_valid_reg [MEM_LATENCY];
    logic [ID_WIDTH-1:0] stage_id_reg    [MEM_LATENCY];
    logic                stage_wen_reg   [MEM_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_valid_reg[gi] <= 1'b0;
                        stage_id_reg[gi]    <= '0;
                        stage_wen_reg[gi]   <= 1'b0;
                    end else begin
                        stage_valid_reg[gi] <= req_gnt_i;
                        stage_id_reg[gi]    <= req_id_i;
                        stage_wen_reg[gi]   <= req_wen_i;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_valid_reg[gi] <= 1'b0;
                        stage_id_reg[gi]    <= '0;
                        stage_wen_reg[gi]   <= 1'b0;
                    end else begin
                        stage_valid_reg[gi] <= stage_valid_reg[gi-1];
                        stage_id_reg[gi]    <= stage_id_reg[gi-1];
                        stage_wen_reg[gi]   <= stage_wen_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic                  last_valid;
    logic                  last_wen;
    logic [31:0]           last_id_ext;
    logic                  in_range;
    logic [N_MASTER-1:0]   dec_valid;
    logic                  dec_drop;
    logic [DATA_WIDTH-1:0] dec_rdata;

    // Widened id keeps the range check meaningful when 2**ID_WIDTH == N_MASTER.
    assign last_valid  = stage_valid_reg[MEM_LATENCY-1];
    assign last_wen    = stage_wen_reg[MEM_LATENCY-1];
    assign last_id_ext = 32'(stage_id_reg[MEM_LATENCY-1]);
    assign in_range    = last_id_ext < 32'(N_MASTER);

    generate
        for (gi = 0; gi < N_MASTER; gi++) begin : g_decode
            assign dec_valid[gi] = last_valid && in_range && (last_id_ext == 32'(gi));
        end
    endgenerate

    assign dec_drop  = last_valid && !in_range;
    assign dec_rdata = (last_valid && in_range && last_wen) ? mem_rdata_i : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [N_MASTER-1:0]   valid_reg;
            logic                  drop_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= '0;
                    drop_reg  <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    valid_reg <= dec_valid;
                    drop_reg  <= dec_drop;
                    rdata_reg <= dec_rdata;
                end
            end

            assign data_r_valid_o = valid_reg;
            assign drop_o         = drop_reg;
            assign data_r_rdata_o = rdata_reg;
        end else begin : g_out_comb
            assign data_r_valid_o = dec_valid;
            assign drop_o         = dec_drop;
            assign data_r_rdata_o = dec_rdata;
        end
    endgenerate

    logic                 leave;
    logic [CNT_WIDTH-1:0] inflight_reg;
    logic [CNT_WIDTH-1:0] inflight_next;

    // A request leaves in the cycle its valid or drop is visible at the output.
    assign leave = (|data_r_valid_o) || drop_o;

    always_comb begin
        inflight_next = inflight_reg;
        if (req_gnt_i && !leave) begin
            inflight_next = inflight_reg + CNT_WIDTH'(1);
        end else if (!req_gnt_i && leave) begin
            inflight_next = inflight_reg - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign inflight_o = inflight_reg;

endmodule
